// File: rtl/period_meter_if.sv
// Measurement bus for period_meter: slow input, consumer handshake and sticky flags.
// The slave modport is the meter side, the master modport is the consumer/stimulus side.
interface period_meter_if #(
  parameter int CNT_W = 26
);
  logic             sig_in;
  logic             meas_ack;
  logic             clr_flags;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             overrun;
  logic             timeout;

  modport master (
    output sig_in,
    output meas_ack,
    output clr_flags,
    input  half_period,
    input  meas_valid,
    input  overrun,
    input  timeout
  );

  modport slave (
    input  sig_in,
    input  meas_ack,
    input  clr_flags,
    output half_period,
    output meas_valid,
    output overrun,
    output timeout
  );
endinterface

// File: rtl/period_meter.sv
// Measures clk_in cycles between consecutive edges (either polarity) of a slow sig_in.
// Define PERIOD_METER_SYNC_EN to add a two-flop synchronizer in front of edge detection.
module period_meter #(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] TIMEOUT = 26'd40_000_000
) (
  input  logic         clk_in,
  input  logic         rst,
  period_meter_if.slave bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  logic w_sample;

`ifdef PERIOD_METER_SYNC_EN
  // Arm delay covers the synchronizer so the first sample through it is never an edge.
  localparam int ARM_DEPTH = 3;

  logic [1:0] r_sync;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], bus.sig_in};
    end
  end

  assign w_sample = r_sync[1];
`else
  localparam int ARM_DEPTH = 1;

  assign w_sample = bus.sig_in;
`endif

  logic [ARM_DEPTH-1:0] r_arm;
  logic                 r_prev;
  logic                 r_edge;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_arm  <= '0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_arm  <= (r_arm << 1) | ARM_DEPTH'(1);
      r_prev <= w_sample;
      r_edge <= r_arm[ARM_DEPTH-1] & (w_sample ^ r_prev);
    end
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_result;
  logic             w_timeout_hit;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // An edge outranks the timeout in the same cycle, so a period of exactly TIMEOUT is measured.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_result      = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_edge) begin
          w_cnt_next   = '0;
          w_state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (r_edge) begin
          w_result   = 1'b1;
          w_cnt_next = '0;
        end else if (w_cnt_inc == TIMEOUT) begin
          w_timeout_hit = 1'b1;
          w_cnt_next    = '0;
          w_state_next  = IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  logic [CNT_W-1:0] r_half_period;
  logic             r_meas_valid;
  logic             r_overrun;
  logic             r_timeout;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_half_period <= '0;
      r_meas_valid  <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_result) begin
        r_half_period <= w_cnt_inc;
      end
      if (w_result) begin
        r_meas_valid <= 1'b1;
      end else if (bus.meas_ack) begin
        r_meas_valid <= 1'b0;
      end
      // Set terms are OR-ed after the clear so a coincident event survives clr_flags.
      r_overrun <= (w_result & r_meas_valid & ~bus.meas_ack) | (r_overrun & ~bus.clr_flags);
      r_timeout <= w_timeout_hit | (r_timeout & ~bus.clr_flags);
    end
  end

  assign bus.half_period = r_half_period;
  assign bus.meas_valid  = r_meas_valid;
  assign bus.overrun     = r_overrun;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus queues timed expectations, a negedge monitor checks them.
// Instance A uses TIMEOUT=100, instance B uses TIMEOUT=20 for the edge-at-timeout boundary.
module tb_period_meter;
  localparam int CNT_W = 26;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int               cyc;
    logic             v;
    logic [CNT_W-1:0] h;
    logic             ov;
    logic             to;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   flush = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  period_meter_if #(.CNT_W(CNT_W)) a_if ();
  period_meter_if #(.CNT_W(CNT_W)) b_if ();

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(26'd100)) dut_a (
    .clk_in (clk),
    .rst    (rst_a),
    .bus    (a_if)
  );

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(26'd20)) dut_b (
    .clk_in (clk),
    .rst    (rst_b),
    .bus    (b_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int dc, input logic v, input int h, input logic ov, input logic to, input string tag);
    exp_t e;
    e.cyc = cyc + dc; e.v = v; e.h = CNT_W'(h); e.ov = ov; e.to = to; e.tag = tag;
    qa.push_back(e);
  endtask

  task automatic push_b(input int dc, input logic v, input int h, input logic ov, input logic to, input string tag);
    exp_t e;
    e.cyc = cyc + dc; e.v = v; e.h = CNT_W'(h); e.ov = ov; e.to = to; e.tag = tag;
    qb.push_back(e);
  endtask

  task automatic toggle_a();
    a_if.sig_in = ~a_if.sig_in;
  endtask

  task automatic toggle_b();
    b_if.sig_in = ~b_if.sig_in;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    step(2);
    push_a(0, 0, 0, 0, 0, "A reset state");
    rst_a = 1'b0;
    step(3);
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    step(2);
    push_b(0, 0, 0, 0, 0, "B reset state");
    rst_b = 1'b0;
    step(3);
  endtask

  task automatic check_entry(input exp_t e, input logic v, input logic [CNT_W-1:0] h,
                             input logic ov, input logic to);
    n_checks++;
    if (e.cyc == cyc && v === e.v && h === e.h && ov === e.ov && to === e.to) begin
      n_pass++;
      $display("check %s @%0d: valid=%0b half=%0d ovr=%0b tmo=%0b ok", e.tag, cyc, v, h, ov, to);
    end else begin
      $display("FAIL %s @%0d (due %0d): got valid=%0b half=%0d ovr=%0b tmo=%0b, want valid=%0b half=%0d ovr=%0b tmo=%0b",
               e.tag, cyc, e.cyc, v, h, ov, to, e.v, e.h, e.ov, e.to);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && (flush || qa[0].cyc <= cyc)) begin
      e = qa.pop_front();
      check_entry(e, a_if.meas_valid, a_if.half_period, a_if.overrun, a_if.timeout);
    end
    while (qb.size() > 0 && (flush || qb[0].cyc <= cyc)) begin
      e = qb.pop_front();
      check_entry(e, b_if.meas_valid, b_if.half_period, b_if.overrun, b_if.timeout);
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.sig_in = 1'b0; a_if.meas_ack = 1'b0; a_if.clr_flags = 1'b0;
    b_if.sig_in = 1'b0; b_if.meas_ack = 1'b0; b_if.clr_flags = 1'b0;
    step(1);

    // Toggle every 5 cycles with ack held high.
    a_if.meas_ack = 1'b1;
    reset_a();
    toggle_a();
    push_a(LAT, 0, 0, 0, 0, "t1 first edge no result");
    for (int k = 0; k < 4; k++) begin
      step(5);
      toggle_a();
      push_a(LAT,     1, 5, 0, 0, "t1 result 5");
      push_a(LAT + 1, 0, 5, 0, 0, "t1 acked");
    end
    step(10);

    // Toggle every 8 cycles without ack: overrun, clear, set-beats-clear.
    a_if.sig_in = 1'b0;
    a_if.meas_ack = 1'b0;
    reset_a();
    toggle_a();
    step(8);
    toggle_a();
    push_a(LAT, 1, 8, 0, 0, "t2 first result 8");
    step(8);
    toggle_a();
    push_a(LAT, 1, 8, 1, 0, "t2 overrun set");
    step(LAT + 1);
    a_if.clr_flags = 1'b1;
    push_a(1, 1, 8, 0, 0, "t2 clr overrun");
    step(1);
    a_if.clr_flags = 1'b0;
    step(8 - LAT - 2);
    toggle_a();
    push_a(LAT, 1, 8, 1, 0, "t2 set beats clr");
    step(LAT - 1);
    a_if.clr_flags = 1'b1;
    step(1);
    a_if.clr_flags = 1'b0;
    a_if.meas_ack = 1'b1;
    push_a(1, 0, 8, 1, 0, "t2 ack clears valid");
    step(1);
    a_if.meas_ack = 1'b0;
    step(10);

    // Ack coinciding with a new result.
    a_if.sig_in = 1'b0;
    reset_a();
    toggle_a();
    step(8);
    toggle_a();
    push_a(LAT, 1, 8, 0, 0, "t3 result 8");
    step(6);
    toggle_a();
    push_a(LAT, 1, 6, 0, 0, "t3 ack with new result");
    step(LAT - 1);
    a_if.meas_ack = 1'b1;
    step(1);
    a_if.meas_ack = 1'b0;
    step(2);
    a_if.meas_ack = 1'b1;
    push_a(1, 0, 6, 0, 0, "t3 ack clears valid");
    step(1);
    a_if.meas_ack = 1'b0;
    step(5);

    // Timeout with TIMEOUT=100.
    a_if.sig_in = 1'b0;
    reset_a();
    toggle_a();
    push_a(LAT + 99,  0, 0, 0, 0, "t4 one cycle before timeout");
    push_a(LAT + 100, 0, 0, 0, 1, "t4 timeout");
    step(LAT + 105);
    toggle_a();
    push_a(LAT, 0, 0, 0, 1, "t4 idle edge only starts");
    step(7);
    toggle_a();
    push_a(LAT, 1, 7, 0, 1, "t4 result after timeout");
    step(LAT + 1);
    a_if.clr_flags = 1'b1;
    push_a(1, 1, 7, 0, 0, "t4 clr timeout");
    step(1);
    a_if.clr_flags = 1'b0;
    step(5);

    // Reset in mid-interval with sig_in high at release.
    a_if.sig_in = 1'b0;
    a_if.meas_ack = 1'b1;
    reset_a();
    toggle_a();
    step(10);
    toggle_a();
    push_a(LAT,     1, 10, 0, 0, "t5 pre-reset 10");
    push_a(LAT + 1, 0, 10, 0, 0, "t5 pre-reset acked");
    step(10);
    toggle_a();
    step(3);
    rst_a = 1'b1;
    a_if.meas_ack = 1'b0;
    step(2);
    push_a(0, 0, 0, 0, 0, "t5 mid-interval reset");
    rst_a = 1'b0;
    step(3);
    push_a(1, 0, 0, 0, 0, "t5 no spurious result");
    step(2);
    toggle_a();
    push_a(LAT, 0, 0, 0, 0, "t5 first edge starts");
    step(10);
    toggle_a();
    push_a(LAT, 1, 10, 0, 0, "t5 resumed 10");
    step(10);

    // Instance B: edge exactly at cnt+1 == TIMEOUT, then a real timeout.
    b_if.meas_ack = 1'b1;
    reset_b();
    toggle_b();
    step(20);
    toggle_b();
    push_b(LAT,     1, 20, 0, 0, "t6 edge at timeout");
    push_b(LAT + 1, 0, 20, 0, 0, "t6 acked");
    step(20);
    toggle_b();
    push_b(LAT,      1, 20, 0, 0, "t6 second 20");
    push_b(LAT + 19, 0, 20, 0, 0, "t6 one before timeout");
    push_b(LAT + 20, 0, 20, 0, 1, "t6 timeout");
    step(LAT + 25);

    flush = 1'b1;
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 26, sets the width of the counter and result in bits.
REQ-002 Parameter TIMEOUT, default 26'd40_000_000, sets the edge-free interval in clk_in cycles (1 s at 40 MHz) after which measurement aborts; legal range is 2 to 2^CNT_W-1.
REQ-003 Port clk_in, input, 1 bit: the single system clock (40 MHz); all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port sig_in, input, 1 bit: the slow square wave to be measured (for example a divided clock).
REQ-006 Port meas_ack, input, 1 bit: consumer acknowledge for the current result.
REQ-007 Port clr_flags, input, 1 bit: single-cycle clear of the sticky flags.
REQ-008 Port half_period, output, CNT_W bits: the measured clk_in cycles between consecutive sig_in edges.
REQ-009 Port meas_valid, output, 1 bit: half_period holds an unacknowledged result.
REQ-010 Port overrun, output, 1 bit: sticky flag, set when a result was overwritten before it was acknowledged.
REQ-011 Port timeout, output, 1 bit: sticky flag, set when no edge arrived within TIMEOUT cycles.

Function
REQ-012 The block SHALL detect both rising and falling edges of sig_in; edge_det is the registered XOR of the current and previous synchronized samples.
REQ-013 Edge detection SHALL be suppressed for the first clk_in cycle after reset (armed bit clear), so a static high level at reset is not counted as an edge.
REQ-014 The FSM SHALL have exactly two states, IDLE and MEASURE, and SHALL reset to IDLE.
REQ-015 In IDLE, on edge_det, the counter SHALL load 0 and the FSM SHALL move to MEASURE; no result is produced.
REQ-016 In MEASURE, with no edge, the counter SHALL increment by 1 per cycle.
REQ-017 In MEASURE, on edge_det, half_period SHALL load cnt+1, the counter SHALL load 0, meas_valid SHALL be 1 on the next cycle, and the FSM SHALL stay in MEASURE.
REQ-018 Edges spaced N cycles apart SHALL yield half_period = N; a source toggling every T+1 cycles yields T+1.
REQ-019 In MEASURE, if cnt+1 == TIMEOUT with no edge in the same cycle, timeout SHALL set, the FSM SHALL return to IDLE, and the counter SHALL clear; the counter never wraps.
REQ-020 If an edge and the timeout condition fall in the same cycle, the edge SHALL take priority: a result is produced and timeout does not set.
REQ-021 meas_valid SHALL clear on the cycle after meas_ack is sampled high while meas_valid = 1; meas_ack while meas_valid = 0 SHALL be ignored.
REQ-022 If a new result arrives while meas_valid = 1 without ack, half_period SHALL be overwritten, meas_valid SHALL stay 1, and overrun SHALL set.
REQ-023 If a new result and meas_ack coincide, the new result SHALL load, meas_valid SHALL stay 1, and overrun SHALL not set.
REQ-024 clr_flags SHALL clear overrun and timeout; a set event in the same cycle SHALL win.

Reset
REQ-025 When rst = 1 at a clk_in edge: half_period = 0, meas_valid = 0, overrun = 0, timeout = 0, counter = 0, FSM = IDLE, armed = 0, and sample/synchronizer flops = 0.
REQ-026 Asserting rst mid-measurement SHALL discard the partial count; the first post-reset edge only starts a measurement.

Configuration
REQ-027 Macro PERIOD_METER_SYNC_EN defined: sig_in SHALL pass through a two-flop synchronizer before edge detection, adding 2 cycles of edge-to-meas_valid latency; measured values are unchanged.
REQ-028 Macro PERIOD_METER_SYNC_EN undefined: sig_in is treated as synchronous to clk_in, sampled directly, with no extra latency.

Verification
REQ-029 Reset, then toggle sig_in every 5 cycles with meas_ack tied high -> the first edge yields no result, then half_period = 5 on every subsequent edge, with no flags.
REQ-030 Apply TIMEOUT = 100 and hold sig_in static after one edge -> timeout = 1 at cycle 100 after the edge, FSM returns to IDLE, and meas_valid stays 0.
REQ-031 Toggle every 8 cycles with meas_ack = 0 -> meas_valid stays 1, half_period = 8, and overrun = 1 after the second result; clr_flags -> overrun = 0.
REQ-032 Pulse meas_ack on the same cycle as a new result -> meas_valid remains 1 and overrun remains 0.
REQ-033 Assert rst 3 cycles into a 10-cycle interval, with sig_in high at reset release -> no spurious result; resumed toggling every 10 cycles yields half_period = 10 from the second post-reset edge onward.
REQ-034 Edge exactly at cnt+1 == TIMEOUT (TIMEOUT = 20, edges 20 cycles apart) -> half_period = 20 and timeout = 0.
